// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and frame defaults
// used by both the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned PARITY_MODE_EVEN = 0;
  localparam int unsigned PARITY_MODE_ODD  = 1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_STOP_BITS  = 1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a parallel word on wr_en and shifts out start, LSB-first
// data, optional parity and stop bits, advancing one bit per clk_en strobe.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = PARITY_MODE_EVEN,
  parameter int unsigned STOP_BITS  = DEFAULT_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic                  wr_en,
  output logic                  tx,
  output logic                  tx_busy
);

  // DATA_WIDTH >= 5 guarantees the counter also covers the stop-bit count.
  localparam int unsigned       CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_DATA  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  LAST_STOP  = CNT_W'(STOP_BITS);
  localparam logic              PARITY_INV = (PARITY_ODD == PARITY_MODE_ODD);
  localparam logic              HAS_PARITY = (PARITY_EN != 0);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  parity_q, parity_d;
  logic                  tx_q,    tx_d;
  logic                  busy_q,  busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // Each state names the bit the next clk_en strobe will put on the line.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (wr_en) begin
          shift_d  = data_input;
          parity_d = (^data_input) ^ PARITY_INV;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (clk_en) begin
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (clk_en) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          if (cnt_q == LAST_DATA) begin
            cnt_d   = '0;
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (clk_en) begin
          tx_d    = parity_q;
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end

      // Strobes 0..STOP_BITS-1 drive stop bits; strobe STOP_BITS closes the frame.
      ST_STOP: begin
        if (clk_en) begin
          tx_d = 1'b1;
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four parameterisations (8N1, 8E1, 8O1, 8N2) share a
// clock and strobe; expected line bits are queued on stimulus and popped per bit strobe.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en = 1'b0;
  logic [7:0] data_input;
  logic [3:0] wr_en;
  logic [3:0] tx;
  logic [3:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  int en_mode = 0;  // 0: strobe off, 1: every clk, 2: every 16th clk
  int en_cnt  = 0;
  int sel     = 0;

  bit exp_q[$];

  int cyc = 0;
  logic edge_en = 1'b0;
  logic busy_pre = 1'b0;
  logic busy_nprev = 1'b0;
  logic tx_prev = 1'b1;
  int bits_in_frame = 0;
  int last_bit_cyc = 0;
  int falls = 0;
  int rises = 0;
  int fall_cyc = 0;
  int last_gap = 0;

  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_input(data_input),
    .wr_en(wr_en[0]), .tx(tx[0]), .tx_busy(busy[0]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_input(data_input),
    .wr_en(wr_en[1]), .tx(tx[1]), .tx_busy(busy[1]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_input(data_input),
    .wr_en(wr_en[2]), .tx(tx[2]), .tx_busy(busy[2]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_input(data_input),
    .wr_en(wr_en[3]), .tx(tx[3]), .tx_busy(busy[3]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (dut %0d, cycle %0d)", tag, obs, exp, sel, cyc);
    end
  endtask

  function automatic bit cfg_parity_en(input int s);
    return (s == 1) || (s == 2);
  endfunction

  function automatic int cfg_stop_bits(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (cfg_parity_en(sel)) exp_q.push_back((^d) ^ (sel == 2));
    for (int i = 0; i < cfg_stop_bits(sel); i++) exp_q.push_back(1'b1);
  endtask

  // Strobe generator: single driver of clk_en, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (en_mode == 2) begin
      clk_en = (en_cnt == 15);
      en_cnt = (en_cnt == 15) ? 0 : en_cnt + 1;
    end else begin
      clk_en = (en_mode == 1);
    end
  end

  // Capture pre-edge strobe and busy for the monitor.
  always @(posedge clk) begin
    cyc++;
    edge_en  = clk_en;
    busy_pre = busy[sel];
  end

  // A strobe edge with busy high before and after drives a new line bit.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_nprev    = 1'b0;
      bits_in_frame = 0;
    end else begin
      if (edge_en && busy_pre && busy[sel]) begin
        check("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_bit", tx[sel], exp_q.pop_front());
        if (en_mode == 2 && bits_in_frame > 0) check("bit_len", cyc - last_bit_cyc, 16);
        last_bit_cyc = cyc;
        bits_in_frame++;
      end else begin
        check("tx_hold", tx[sel], tx_prev);
      end
      if (busy_nprev && !busy[sel]) begin
        falls++;
        fall_cyc = cyc;
        check("frame_len", bits_in_frame, 1 + 8 + cfg_parity_en(sel) + cfg_stop_bits(sel));
        bits_in_frame = 0;
      end
      if (!busy_nprev && busy[sel]) begin
        rises++;
        last_gap = cyc - fall_cyc;
      end
      busy_nprev = busy[sel];
    end
    tx_prev = tx[sel];
  end

  task automatic send(input logic [7:0] d);
    push_frame(d);
    @(posedge clk); #2;
    data_input = d;
    wr_en[sel] = 1'b1;
    @(posedge clk); #2;
    wr_en[sel] = 1'b0;
    check("busy_rise", busy[sel], 1);
    check("tx_before_start", tx[sel], 1);
  endtask

  task automatic wait_fall(input int max_cyc);
    int start;
    bit got;
    start = falls;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (falls > start) begin
        got = 1'b1;
        break;
      end
    end
    check("fall_timeout", got, 1);
  endtask

  initial begin
    bit got;
    rst_n      = 1'b0;
    wr_en      = '0;
    data_input = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", tx[i], 1);
      check("rst_busy", busy[i], 0);
    end
    rst_n   = 1'b1;
    en_mode = 1;
    repeat (10) @(posedge clk);
    #2;
    check("idle_tx", tx[0], 1);
    check("idle_busy", busy[0], 0);

    // 8N1, one bit per clk
    sel = 0;
    send(8'h61);
    wait_fall(40);
    for (int k = 0; k < 3; k++) begin
      send(8'($urandom_range(0, 255)));
      wait_fall(40);
    end

    // wr_en held high: exactly two frames, separated by an idle clk
    falls = 0;
    rises = 0;
    push_frame(8'h61);
    push_frame(8'h61);
    @(posedge clk); #2;
    data_input = 8'h61;
    wr_en[0]   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (rises >= 2) begin
        got = 1'b1;
        break;
      end
    end
    check("held_rise_timeout", got, 1);
    wr_en[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (falls >= 2) begin
        got = 1'b1;
        break;
      end
    end
    check("held_fall_timeout", got, 1);
    check("held_falls", falls, 2);
    check("idle_gap", last_gap >= 1, 1);
    repeat (20) @(posedge clk);
    #2;
    check("held_no_third", busy[0], 0);
    check("held_q_empty", exp_q.size(), 0);

    // Slow strobe; late data change and wr_en while busy must not disturb the frame
    en_mode = 2;
    send(8'h61);
    repeat (40) @(posedge clk);
    #2;
    data_input = 8'hFF;
    wr_en[0]   = 1'b1;
    @(posedge clk); #2;
    wr_en[0]   = 1'b0;
    wait_fall(16 * 12 + 40);
    repeat (40) @(posedge clk);
    #2;
    check("slow_no_extra", busy[0], 0);
    check("slow_q_empty", exp_q.size(), 0);

    // Reset mid-frame aborts at once and the frame does not resume
    send(8'hA5);
    repeat (70) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx[0], 1);
    check("abort_busy", busy[0], 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    en_mode = 1;
    repeat (30) @(posedge clk);
    #2;
    check("post_rst_tx", tx[0], 1);
    check("post_rst_busy", busy[0], 0);

    // Even parity, odd parity, two stop bits
    for (int s = 1; s < 4; s++) begin
      sel = s;
      repeat (2) @(posedge clk);
      send(8'h61);
      wait_fall(40);
      for (int k = 0; k < 3; k++) begin
        send(8'($urandom_range(0, 255)));
        wait_fall(40);
      end
    end
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
